// File: rtl/inert_intf_mc.sv
// inert_intf_mc
//   Drives an external 16-bit SPI master transceiver for an inertial sensor.
//   After reset it waits 2^INIT_WAIT_BITS clocks, then writes four
//   configuration words. After that, every rising edge of INT starts a burst
//   read of NUM_CH 16-bit channels. Each channel is read as a low byte and a
//   high byte. All channels are published together with a one-cycle vld
//   strobe. ovr reports that an INT rise was dropped during that burst.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   INT      in   sensor data-ready (asynchronous, rising edge meaningful)
//   done     in   transceiver transaction complete (1-cycle pulse)
//   rd_data  in   transceiver read data, returned byte in [7:0]
//   wrt      out  1-cycle request to start a transaction
//   cmd      out  command word, held from wrt until done
//   data     out  channel c at data[16c +: 16]
//   vld      out  1-cycle strobe, data updated this cycle
//   ovr      out  an INT rise was dropped during the burst behind data
//   busy     out  high in every state except IDLE
module inert_intf_mc #(
    parameter int unsigned NUM_CH         = 2,
    parameter logic [6:0]  BASE_ADDR      = 7'h22,
    parameter int unsigned INIT_WAIT_BITS = 16,
    parameter logic [15:0] INIT_CMD0      = 16'h0D02,
    parameter logic [15:0] INIT_CMD1      = 16'h1053,
    parameter logic [15:0] INIT_CMD2      = 16'h1150,
    parameter logic [15:0] INIT_CMD3      = 16'h1460
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   INT,
    input  logic                   done,
    input  logic [15:0]            rd_data,
    output logic                   wrt,
    output logic [15:0]            cmd,
    output logic [16*NUM_CH-1:0]   data,
    output logic                   vld,
    output logic                   ovr,
    output logic                   busy
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        INIT_WAIT,
        INIT_WR,
        IDLE,
        RD_LO,
        RD_HI,
        UPDATE
    } state_t;

    state_t                      state_q, state_d;
    logic [INIT_WAIT_BITS-1:0]   cnt_q, cnt_d;
    logic [1:0]                  k_q, k_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic                        pend_q, pend_d;
    logic                        oflag_q, oflag_d;
    logic [2:0]                  int_sync_q, int_sync_d;
    logic                        wrt_q, wrt_d;
    logic [15:0]                 cmd_q, cmd_d;
    logic [NUM_CH-1:0][15:0]     shadow_q, shadow_d;
    logic [NUM_CH-1:0][15:0]     data_q, data_d;
    logic                        vld_q, vld_d;
    logic                        ovr_q, ovr_d;
    logic                        busy_q, busy_d;

    logic                        edge_pulse;
    logic                        done_ok;
    logic [6:0]                  lo_addr;
    logic [6:0]                  hi_addr;
    logic                        rd_hi_unused;

    // Bits 0/1 synchronise INT, bit 2 is the delayed copy for edge detect.
    assign edge_pulse = int_sync_q[1] & ~int_sync_q[2];

    // A done is only meaningful while a transaction is outstanding; one
    // arriving in the wrt cycle itself cannot belong to this transaction.
    assign done_ok = done & pend_q & ~wrt_q;

    // Register addresses wrap naturally in 7 bits.
    assign lo_addr = BASE_ADDR + 7'({ch_q, 1'b0});
    assign hi_addr = lo_addr + 7'd1;

    assign rd_hi_unused = ^rd_data[15:8];

    always_comb begin
        int_sync_d = {int_sync_q[1:0], INT};
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        ch_d       = ch_q;
        pend_d     = pend_q;
        oflag_d    = oflag_q;
        wrt_d      = 1'b0;
        cmd_d      = cmd_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        vld_d      = 1'b0;
        ovr_d      = ovr_q;

        case (state_q)
            INIT_WAIT: begin
                cnt_d = cnt_q + INIT_WAIT_BITS'(1);
                if (cnt_d == '1) begin
                    state_d = INIT_WR;
                    k_d     = '0;
                end
            end

            INIT_WR: begin
                if (!pend_q) begin
                    wrt_d  = 1'b1;
                    pend_d = 1'b1;
                    case (k_q)
                        2'd0:    cmd_d = INIT_CMD0;
                        2'd1:    cmd_d = INIT_CMD1;
                        2'd2:    cmd_d = INIT_CMD2;
                        default: cmd_d = INIT_CMD3;
                    endcase
                end else if (done_ok) begin
                    pend_d = 1'b0;
                    if (k_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end

            IDLE: begin
                if (edge_pulse) begin
                    ch_d    = '0;
                    oflag_d = 1'b0;
                    state_d = RD_LO;
                end
            end

            RD_LO: begin
                if (edge_pulse) begin
                    oflag_d = 1'b1;
                end
                if (!pend_q) begin
                    wrt_d  = 1'b1;
                    pend_d = 1'b1;
                    cmd_d  = {1'b1, lo_addr, 8'h00};
                end else if (done_ok) begin
                    shadow_d[ch_q][7:0] = rd_data[7:0];
                    pend_d  = 1'b0;
                    state_d = RD_HI;
                end
            end

            RD_HI: begin
                if (edge_pulse) begin
                    oflag_d = 1'b1;
                end
                if (!pend_q) begin
                    wrt_d  = 1'b1;
                    pend_d = 1'b1;
                    cmd_d  = {1'b1, hi_addr, 8'h00};
                end else if (done_ok) begin
                    shadow_d[ch_q][15:8] = rd_data[7:0];
                    pend_d = 1'b0;
                    if (ch_q == LAST_CH) begin
                        // Publish on entry to UPDATE so vld, data and ovr all
                        // appear during the UPDATE cycle, final byte included.
                        state_d = UPDATE;
                        data_d  = shadow_d;
                        vld_d   = 1'b1;
                        ovr_d   = oflag_d;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = RD_LO;
                    end
                end
            end

            UPDATE: begin
                if (edge_pulse) begin
                    oflag_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = INIT_WAIT;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_WAIT;
            cnt_q      <= '0;
            k_q        <= '0;
            ch_q       <= '0;
            pend_q     <= 1'b0;
            oflag_q    <= 1'b0;
            int_sync_q <= '0;
            wrt_q      <= 1'b0;
            cmd_q      <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            ch_q       <= ch_d;
            pend_q     <= pend_d;
            oflag_q    <= oflag_d;
            int_sync_q <= int_sync_d;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign wrt  = wrt_q;
    assign cmd  = cmd_q;
    assign data = data_q;
    assign vld  = vld_q;
    assign ovr  = ovr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_inert_intf_mc.sv
// tb_inert_intf_mc
//   Self-checking bench for inert_intf_mc. The bench plays the SPI
//   transceiver (random reply latency and bytes), raises INT, and keeps two
//   expectation queues: the command words the sensor should see, and the
//   channel data/ovr that each burst should publish.
module tb_inert_intf_mc;

    localparam int unsigned NCH  = 3;
    localparam logic [6:0]  BASE = 7'h7E;
    localparam int unsigned IWB  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 INT;
    logic                 done;
    logic                 done_r;
    logic                 done_s;
    logic [15:0]          rd_data;
    logic                 wrt;
    logic [15:0]          cmd;
    logic [16*NCH-1:0]    data;
    logic                 vld;
    logic                 ovr;
    logic                 busy;

    assign done = done_r | done_s;

    inert_intf_mc #(
        .NUM_CH         (NCH),
        .BASE_ADDR      (BASE),
        .INIT_WAIT_BITS (IWB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .data    (data),
        .vld     (vld),
        .ovr     (ovr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0]       cmd_q[$];
    logic [16*NCH-1:0] dexp_q[$];
    logic              oexp_q[$];

    int vld_cnt    = 0;
    int rd_wrt_cnt = 0;
    logic ovr_inj  = 1'b0;
    bit   spur_wrt_req = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_init();
        cmd_q.push_back(16'h0D02);
        cmd_q.push_back(16'h1053);
        cmd_q.push_back(16'h1150);
        cmd_q.push_back(16'h1460);
    endtask

    // Burst reads registers BASE, BASE+1, ... in order, modulo 128.
    task automatic push_burst();
        logic [6:0] a7;
        for (int i = 0; i < 2*NCH; i++) begin
            a7 = 7'((int'(BASE) + i) % 128);
            cmd_q.push_back({1'b1, a7, 8'h00});
        end
    endtask

    task automatic release_and_time_first_wrt();
        int n;
        @(negedge clk);
        rst = 1'b0;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (wrt) break;
        end
        chk("first_wrt_clock", 64'(n), 64'd16);
        chk("first_cmd", 64'(cmd), 64'h0D02);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(nm, 64'(i < 2000), 64'd1);
    endtask

    task automatic wait_rd_wrt(input int target, input string nm);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (rd_wrt_cnt >= target) break;
            @(negedge clk);
        end
        chk(nm, 64'(i < 2000), 64'd1);
    endtask

    task automatic wait_vld(input int nv, input string nm);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (vld_cnt > nv) break;
        end
        chk(nm, 64'(i < 2000), 64'd1);
    endtask

    task automatic int_pulse();
        @(negedge clk);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        INT = 1'b0;
    endtask

    // SPI transceiver model and command scoreboard.
    initial begin : responder
        logic [15:0]       c;
        logic [7:0]        b;
        logic [7:0]        bytes[$];
        logic [16*NCH-1:0] pk;
        int                d;
        bit                aborted;
        bit                bad;
        bit                skip;
        done_r  = 1'b0;
        rd_data = '0;
        skip    = 1'b0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (rst) begin
                bytes.delete();
                done_r = 1'b0;
            end else if (wrt) begin
                c = cmd;
                if (cmd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wrt: got cmd %0h expected no transaction", c);
                end else begin
                    chk("cmd", 64'(c), 64'(cmd_q.pop_front()));
                end
                if (c[15]) rd_wrt_cnt++;
                if (spur_wrt_req) begin
                    done_r = 1'b1;
                    spur_wrt_req = 1'b0;
                end
                d = $urandom_range(1, 6);
                aborted = 1'b0;
                bad = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    done_r = 1'b0;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (wrt || cmd !== c) bad = 1'b1;
                end
                if (!aborted) begin
                    b = 8'($urandom);
                    rd_data = {8'($urandom), b};
                    if (c[15]) begin
                        bytes.push_back(b);
                        if (bytes.size() == 2*NCH) begin
                            for (int ch = 0; ch < NCH; ch++)
                                pk[16*ch +: 16] = {bytes[2*ch+1], bytes[2*ch]};
                            dexp_q.push_back(pk);
                            oexp_q.push_back(ovr_inj);
                            bytes.delete();
                        end
                    end
                    done_r = 1'b1;
                    @(negedge clk);
                    done_r = 1'b0;
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        tests++;
                        if (bad) begin
                            fails++;
                            $display("FAIL xact_rule: cmd %0h changed or wrt repeated, got 1 expected 0", c);
                        end
                        skip = 1'b1;
                    end
                end
                if (aborted) begin
                    bytes.delete();
                    done_r = 1'b0;
                end
            end
        end
    end

    // Output monitor: checks every published result against the queue.
    initial begin : monitor
        logic [16*NCH-1:0] e;
        logic              eo;
        bit                have;
        forever begin
            @(negedge clk);
            if (!rst && vld) begin
                vld_cnt++;
                have = 1'b0;
                if (dexp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_vld: got data %0h expected no update", data);
                end else begin
                    e  = dexp_q.pop_front();
                    eo = oexp_q.pop_front();
                    have = 1'b1;
                    chk("data", 64'(data), 64'(e));
                    chk("ovr", 64'(ovr), 64'(eo));
                end
                chk("busy_at_vld", 64'(busy), 64'd1);
                @(negedge clk);
                if (!rst) begin
                    chk("vld_width", 64'(vld), 64'd0);
                    chk("busy_after_vld", 64'(busy), 64'd0);
                    if (have) chk("data_hold", 64'(data), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int nv;
        rst    = 1'b1;
        INT    = 1'b0;
        done_s = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_wrt",  64'(wrt),  64'd0);
        chk("rst_cmd",  64'(cmd),  64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_vld",  64'(vld),  64'd0);
        chk("rst_ovr",  64'(ovr),  64'd0);
        chk("rst_busy", 64'(busy), 64'd1);

        // Power-up sequence with INT activity that must be ignored.
        push_init();
        fork
            release_and_time_first_wrt();
            begin
                repeat (4) @(negedge clk);
                INT = 1'b1;
                repeat (2) @(negedge clk);
                INT = 1'b0;
                repeat (2) @(negedge clk);
                INT = 1'b1;
                @(negedge clk);
                INT = 1'b0;
            end
        join
        int_pulse();
        wait_idle("init_timeout");
        repeat (10) @(negedge clk);
        chk("init_cmds_left", 64'(cmd_q.size()), 64'd0);
        chk("init_idle", 64'(busy), 64'd0);
        chk("init_ovr", 64'(ovr), 64'd0);
        chk("init_data", 64'(data), 64'd0);

        // Stray done while idle.
        @(negedge clk);
        done_s = 1'b1;
        @(negedge clk);
        done_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_idle_busy", 64'(busy), 64'd0);
        chk("spur_idle_cmd", 64'(cmd), 64'h1460);

        // Bursts: #1 has a stray done in its first wrt cycle,
        // #2 and #4 get a second INT rise mid-burst.
        for (int b = 0; b < 6; b++) begin
            ovr_inj = 1'b0;
            if (b == 1) spur_wrt_req = 1'b1;
            push_burst();
            base = rd_wrt_cnt;
            nv   = vld_cnt;
            int_pulse();
            if (b == 2 || b == 4) begin
                wait_rd_wrt(base + 3, "ovr_inject_timeout");
                ovr_inj = 1'b1;
                int_pulse();
            end
            wait_vld(nv, "burst_timeout");
            repeat (8) @(negedge clk);
            chk("burst_cmds_left", 64'(cmd_q.size()), 64'd0);
            chk("burst_idle", 64'(busy), 64'd0);
        end

        // Reset during the high-byte read of channel 1.
        ovr_inj = 1'b0;
        push_burst();
        base = rd_wrt_cnt;
        int_pulse();
        wait_rd_wrt(base + 4, "rd_hi1_timeout");
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_wrt",  64'(wrt),  64'd0);
        chk("midrst_cmd",  64'(cmd),  64'd0);
        chk("midrst_data", 64'(data), 64'd0);
        chk("midrst_vld",  64'(vld),  64'd0);
        chk("midrst_ovr",  64'(ovr),  64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        cmd_q.delete();
        dexp_q.delete();
        oexp_q.delete();
        repeat (3) @(negedge clk);

        push_init();
        release_and_time_first_wrt();
        wait_idle("reinit_timeout");
        ovr_inj = 1'b0;
        push_burst();
        nv = vld_cnt;
        int_pulse();
        wait_vld(nv, "post_rst_burst_timeout");
        repeat (8) @(negedge clk);
        chk("final_cmds_left", 64'(cmd_q.size()), 64'd0);
        chk("final_data_left", 64'(dexp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
